fht_control_cg: RTL

Parametrised successor of fht_control. It generates the read, write and coefficient addresses and the control strobes for a radix-4 constant-geometry (Pease) FHT over N = 2^N_LOG2 points. The points are held in 4 skewed banks of depth D = 2^A_BIT, ping-ponged between memory A and memory B. New over the previous controller: size, pipeline latency and coefficient width are parameters; bank skewing removes bank conflicts; it has a rotation output for the data crossbar and an abort input.

---
 rtl/fht_cg_pkg.sv | 31 +++
 rtl/fht_cg_addr_map.sv | 27 ++
 rtl/fht_control_cg.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/fht_cg_pkg.sv
// Shared types and helpers for the radix-4 constant-geometry FHT controller.
package fht_cg_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    TURN = 2'd2
  } fht_state_t;

  // Default geometry (N = 1024): bank depth and stage count.
  localparam int unsigned D = 256;
  localparam int unsigned S = 5;

  // Sum of the radix-4 digits of k, modulo 4; this is the bank holding element k.
  function automatic logic [1:0] digsum_mod4(input logic [31:0] k);
    logic [1:0] acc;
    acc = 2'd0;
    for (int i = 0; i < 16; i++) begin
      acc = acc + k[2*i +: 2];
    end
    return acc;
  endfunction

  // Mask that clears the low 2*(n_stages-1-stage) bits of the read index.
  function automatic logic [31:0] coef_mask(input int stage, input int n_stages);
    int sh;
    sh = 2 * (n_stages - 1 - stage);
    return ~((32'd1 << sh) - 32'd1);
  endfunction

endpackage

// File: rtl/fht_cg_addr_map.sv
// Read-side skewed bank map: index k -> per-bank read address and crossbar rotation.
module fht_cg_addr_map
  import fht_cg_pkg::*;
#(
  parameter int A_BIT = 8
) (
  input  logic [A_BIT-1:0] k,
  output logic [1:0]       rot,
  output logic [A_BIT-1:0] addr_0,
  output logic [A_BIT-1:0] addr_1,
  output logic [A_BIT-1:0] addr_2,
  output logic [A_BIT-1:0] addr_3
);

  logic [1:0] r;

  assign r   = digsum_mod4(32'(k));
  assign rot = r;

  // Operand m = (b - r) mod 4 sits in bank b; its element index is m*D + k,
  // so the bank address (index >> 2) is {m, k[A_BIT-1:2]}.
  assign addr_0 = {2'd0 - r, k[A_BIT-1:2]};
  assign addr_1 = {2'd1 - r, k[A_BIT-1:2]};
  assign addr_2 = {2'd2 - r, k[A_BIT-1:2]};
  assign addr_3 = {2'd3 - r, k[A_BIT-1:2]};

endmodule

// File: rtl/fht_control_cg.sv
// Address and strobe controller for a radix-4 constant-geometry FHT with
// four skewed, ping-ponged memory banks.
module fht_control_cg
  import fht_cg_pkg::*;
#(
  parameter int N_LOG2   = 10,
  parameter int A_BIT    = N_LOG2 - 2,
  parameter int STAGES   = N_LOG2 / 2,
  parameter int PIPE_LAT = 4,
  parameter int C_BIT    = N_LOG2 - 2
) (
  input  logic                        iCLK,
  input  logic                        iRESET,
  input  logic                        iSTART,
  input  logic                        iABORT,
  output logic [A_BIT-1:0]            oADDR_RD_0,
  output logic [A_BIT-1:0]            oADDR_RD_1,
  output logic [A_BIT-1:0]            oADDR_RD_2,
  output logic [A_BIT-1:0]            oADDR_RD_3,
  output logic [1:0]                  oROT_RD,
  output logic [A_BIT-1:0]            oADDR_WR_0,
  output logic [A_BIT-1:0]            oADDR_WR_1,
  output logic [A_BIT-1:0]            oADDR_WR_2,
  output logic [A_BIT-1:0]            oADDR_WR_3,
  output logic [1:0]                  oROT_WR,
  output logic [C_BIT-1:0]            oADDR_COEF,
  output logic                        oWE_A,
  output logic                        oWE_B,
  output logic                        oSOURCE_DATA,
  output logic [$clog2(STAGES)-1:0]   oSTAGE,
  output logic                        oST_ZERO,
  output logic                        oST_LAST,
  output logic                        oRES_IN_B,
  output logic                        oRDY
);

  localparam int DEPTH = 1 << A_BIT;
  localparam int TW    = A_BIT + 2;
  localparam int SW    = $clog2(STAGES);

  // Phase t runs 0 .. DEPTH+PIPE_LAT-1 within a stage; reads for t < DEPTH,
  // writes for t >= PIPE_LAT, and the final phase is spent in TURN.
  localparam logic [TW-1:0] T_LAST   = TW'(DEPTH + PIPE_LAT - 1);
  localparam logic [TW-1:0] T_DEPTH  = TW'(DEPTH);
  localparam logic [TW-1:0] T_LAT    = TW'(PIPE_LAT);
  localparam logic [SW-1:0] STG_LAST = SW'(STAGES - 1);

  fht_state_t      state, state_nxt;
  logic [SW-1:0]   stage_idx, stage_nxt;
  logic [TW-1:0]   t_cnt, t_nxt;

  logic            busy_p0;
  logic            vld_rd_p0;
  logic            vld_wr_p0;
  logic [A_BIT-1:0] k_p0;
  logic [A_BIT-1:0] kw_p0;
  logic [1:0]      rot_wr_p0;
  logic [31:0]     coef_full_p0;
  logic [1:0]      map_rot_p0;
  logic [A_BIT-1:0] map_addr0_p0, map_addr1_p0, map_addr2_p0, map_addr3_p0;

  assign oRES_IN_B = ((STAGES % 2) == 1);

  // State, stage and phase registers.
  always_ff @(posedge iCLK) begin
    if (!iRESET) begin
      state     <= IDLE;
      stage_idx <= '0;
      t_cnt     <= '0;
    end else begin
      state     <= state_nxt;
      stage_idx <= stage_nxt;
      t_cnt     <= t_nxt;
    end
  end

  // Next-state logic; abort overrides everything and parks the counters at 0.
  always_comb begin
    state_nxt = state;
    stage_nxt = stage_idx;
    t_nxt     = t_cnt;
    unique case (state)
      IDLE: begin
        if (iSTART) begin
          state_nxt = RUN;
          stage_nxt = '0;
          t_nxt     = '0;
        end
      end
      RUN: begin
        t_nxt = t_cnt + TW'(1);
        if (t_nxt == T_LAST) begin
          state_nxt = TURN;
        end
      end
      TURN: begin
        t_nxt = '0;
        if (stage_idx == STG_LAST) begin
          state_nxt = IDLE;
          stage_nxt = '0;
        end else begin
          state_nxt = RUN;
          stage_nxt = stage_idx + SW'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        stage_nxt = '0;
        t_nxt     = '0;
      end
    endcase
    if (iABORT) begin
      state_nxt = IDLE;
      stage_nxt = '0;
      t_nxt     = '0;
    end
  end

  // ---- stage p0: decode the upcoming cycle from the next-state values ----
  assign busy_p0      = (state_nxt != IDLE);
  assign vld_rd_p0    = busy_p0 && (t_nxt < T_DEPTH);
  assign vld_wr_p0    = busy_p0 && (t_nxt >= T_LAT);
  assign k_p0         = t_nxt[A_BIT-1:0];
  assign kw_p0        = A_BIT'(t_nxt - T_LAT);
  assign rot_wr_p0    = digsum_mod4(32'(kw_p0));
  assign coef_full_p0 = 32'(k_p0) & coef_mask(int'(stage_nxt), STAGES);

  fht_cg_addr_map #(
    .A_BIT (A_BIT)
  ) u_addr_map (
    .k      (k_p0),
    .rot    (map_rot_p0),
    .addr_0 (map_addr0_p0),
    .addr_1 (map_addr1_p0),
    .addr_2 (map_addr2_p0),
    .addr_3 (map_addr3_p0)
  );

  // ---- stage p1: registered outputs, idle values whenever a side is inactive ----
  always_ff @(posedge iCLK) begin
    if (!iRESET) begin
      oADDR_RD_0   <= '0;
      oADDR_RD_1   <= '0;
      oADDR_RD_2   <= '0;
      oADDR_RD_3   <= '0;
      oROT_RD      <= '0;
      oADDR_WR_0   <= '0;
      oADDR_WR_1   <= '0;
      oADDR_WR_2   <= '0;
      oADDR_WR_3   <= '0;
      oROT_WR      <= '0;
      oADDR_COEF   <= '0;
      oWE_A        <= 1'b0;
      oWE_B        <= 1'b0;
      oSOURCE_DATA <= 1'b0;
      oSTAGE       <= '0;
      oST_ZERO     <= 1'b0;
      oST_LAST     <= 1'b0;
      oRDY         <= 1'b1;
    end else begin
      oADDR_RD_0   <= vld_rd_p0 ? map_addr0_p0 : '0;
      oADDR_RD_1   <= vld_rd_p0 ? map_addr1_p0 : '0;
      oADDR_RD_2   <= vld_rd_p0 ? map_addr2_p0 : '0;
      oADDR_RD_3   <= vld_rd_p0 ? map_addr3_p0 : '0;
      oROT_RD      <= vld_rd_p0 ? map_rot_p0 : '0;
      oADDR_COEF   <= vld_rd_p0 ? C_BIT'(coef_full_p0) : '0;
      oADDR_WR_0   <= vld_wr_p0 ? kw_p0 : '0;
      oADDR_WR_1   <= vld_wr_p0 ? kw_p0 : '0;
      oADDR_WR_2   <= vld_wr_p0 ? kw_p0 : '0;
      oADDR_WR_3   <= vld_wr_p0 ? kw_p0 : '0;
      oROT_WR      <= vld_wr_p0 ? rot_wr_p0 : '0;
      oWE_A        <= vld_wr_p0 && stage_nxt[0];
      oWE_B        <= vld_wr_p0 && !stage_nxt[0];
      oSOURCE_DATA <= busy_p0 && stage_nxt[0];
      oSTAGE       <= stage_nxt;
      oST_ZERO     <= busy_p0 && (stage_nxt == '0);
      oST_LAST     <= busy_p0 && (stage_nxt == STG_LAST);
      oRDY         <= !busy_p0;
    end
  end

endmodule
